// File: rtl/instr_encoder_loader_pkg.sv
// Shared field widths, opcode/condition encodings, FSM states and the field
// bundle used by the instruction loader and its packer.
package instr_encoder_loader_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned COND_W  = 4;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned OPND_W  = 24;

  localparam logic [OP_W-1:0] OP_DP  = 2'b00;
  localparam logic [OP_W-1:0] OP_MEM = 2'b01;
  localparam logic [OP_W-1:0] OP_BR  = 2'b10;
  localparam logic [OP_W-1:0] OP_ILL = 2'b11;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'h0, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [COND_W-1:0]  cond;
    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic [REG_W-1:0]   rn;
    logic [REG_W-1:0]   rd;
    logic [OPND_W-1:0]  operand;
  } bundle_t;

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational field->word packer for the ARM-subset instruction format.
module instr_pack
  import instr_encoder_loader_pkg::*;
(
  input  bundle_t             bundle,
  output logic [WORD_W-1:0]   word_c
);

  // Branches keep only funct[5:4] and the full imm24; illegal op packs to zero.
  always_comb begin
    word_c = '0;
    case (bundle.op)
      OP_DP, OP_MEM: word_c = {bundle.cond, bundle.op, bundle.funct,
                               bundle.rn, bundle.rd, bundle.operand[11:0]};
      OP_BR:         word_c = {bundle.cond, OP_BR, bundle.funct[5:4], bundle.operand};
      default:       word_c = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts field bundles over valid/ready, packs them and writes them
// sequentially into instruction memory until last, overflow or illegal op.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       DEPTH     = 64,
  localparam int unsigned      CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COND_W-1:0]    in_cond,
  input  logic [OP_W-1:0]      in_op,
  input  logic [FUNCT_W-1:0]   in_funct,
  input  logic [REG_W-1:0]     in_rn,
  input  logic [REG_W-1:0]     in_rd,
  input  logic [OPND_W-1:0]    in_operand,
  input  logic                 in_last,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [WORD_W-1:0]    imem_wdata,
  input  logic                 imem_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     count
);

  state_e              state;
  state_e              state_nxt;
  logic                last_q;
  bundle_t             bundle;
  logic [WORD_W-1:0]   word_c;
  logic [CNT_W-1:0]    count_inc_c;
  logic                start_ok_c;
  logic                accept_c;
  logic                illegal_c;
  logic                write_fire_c;
  logic                full_c;

  assign bundle = '{cond: in_cond, op: in_op, funct: in_funct,
                    rn: in_rn, rd: in_rd, operand: in_operand};

  instr_pack u_pack (
    .bundle (bundle),
    .word_c (word_c)
  );

  assign count_inc_c  = count + CNT_W'(1);
  assign full_c       = (count_inc_c == CNT_W'(DEPTH));
  assign start_ok_c   = start && (state == ST_IDLE || state == ST_DONE);
  assign accept_c     = (state == ST_LOAD) && in_valid;
  assign illegal_c    = (in_op == OP_ILL);
  assign write_fire_c = (state == ST_WRITE) && imem_ready;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (in_valid) state_nxt = illegal_c ? ST_DONE : ST_WRITE;
      ST_WRITE: if (imem_ready) state_nxt = (last_q || full_c) ? ST_DONE : ST_LOAD;
      ST_DONE:  if (start) state_nxt = ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      count      <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == ST_LOAD);
      busy     <= (state_nxt == ST_LOAD) || (state_nxt == ST_WRITE);
      imem_we  <= (state_nxt == ST_WRITE);
      done     <= (state_nxt == ST_DONE) && (state != ST_DONE);

      if (start_ok_c) begin
        imem_addr <= BASE_ADDR;
        count     <= '0;
        err       <= 1'b0;
      end

      if (accept_c && !illegal_c) begin
        imem_wdata <= word_c;
        last_q     <= in_last;
      end

      if (accept_c && illegal_c) err <= 1'b1;

      // Reaching DEPTH without a last-flagged word is an overflow.
      if (write_fire_c) begin
        count     <= count_inc_c;
        imem_addr <= imem_addr + ADDR_W'(4);
        if (!last_q && full_c) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed table-driven bench for instr_encoder_loader, plus hand sequences
// for illegal op, reset mid-write and overflow on a DEPTH=4 instance.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start_b, in_valid, in_last, imem_ready;
  logic [3:0]  in_cond, in_rn, in_rd;
  logic [1:0]  in_op;
  logic [5:0]  in_funct;
  logic [23:0] in_operand;

  logic        in_ready_a, imem_we_a, busy_a, done_a, err_a;
  logic [31:0] imem_addr_a, imem_wdata_a;
  logic [6:0]  count_a;
  logic        in_ready_b, imem_we_b, busy_b, done_b, err_b;
  logic [31:0] imem_addr_b, imem_wdata_b;
  logic [2:0]  count_b;

  instr_encoder_loader dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_cond(in_cond), .in_op(in_op), .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd),
    .in_operand(in_operand), .in_last(in_last), .imem_we(imem_we_a), .imem_addr(imem_addr_a),
    .imem_wdata(imem_wdata_a), .imem_ready(imem_ready), .busy(busy_a), .done(done_a),
    .err(err_a), .count(count_a)
  );

  instr_encoder_loader #(.DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_cond(in_cond), .in_op(in_op), .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd),
    .in_operand(in_operand), .in_last(in_last), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
    .imem_wdata(imem_wdata_b), .imem_ready(imem_ready), .busy(busy_b), .done(done_b),
    .err(err_b), .count(count_b)
  );

  typedef struct {
    logic        new_session;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [23:0] operand;
    logic        last;
    int          stall;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [6:0]  exp_count;
  } vec_t;

  vec_t vecs [4];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_cond    = v.cond;
    in_op      = v.op;
    in_funct   = v.funct;
    in_rn      = v.rn;
    in_rd      = v.rd;
    in_operand = v.operand;
    in_last    = v.last;
  endtask

  // Optionally opens a session, hands one bundle to dut_a and follows its write.
  task automatic run_vec(input vec_t v, input int idx);
    if (v.new_session) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("v%0d start in_ready", idx), 32'(in_ready_a), 32'd1);
      check($sformatf("v%0d start count", idx), 32'(count_a), 32'd0);
    end
    drive(v);
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !in_ready_a; k++) tick();
    check($sformatf("v%0d ready before timeout", idx), 32'(in_ready_a), 32'd1);
    tick();
    in_valid = 1'b0;
    check($sformatf("v%0d we", idx), 32'(imem_we_a), 32'd1);
    check($sformatf("v%0d addr", idx), imem_addr_a, v.exp_addr);
    check($sformatf("v%0d wdata", idx), imem_wdata_a, v.exp_data);
    check($sformatf("v%0d in_ready in write", idx), 32'(in_ready_a), 32'd0);
    if (v.stall > 0) begin
      imem_ready = 1'b0;
      for (int s = 0; s < v.stall; s++) begin
        tick();
        check($sformatf("v%0d stall%0d we", idx, s), 32'(imem_we_a), 32'd1);
        check($sformatf("v%0d stall%0d addr", idx, s), imem_addr_a, v.exp_addr);
        check($sformatf("v%0d stall%0d wdata", idx, s), imem_wdata_a, v.exp_data);
        check($sformatf("v%0d stall%0d in_ready", idx, s), 32'(in_ready_a), 32'd0);
      end
      imem_ready = 1'b1;
    end
    tick();
    check($sformatf("v%0d we after write", idx), 32'(imem_we_a), 32'd0);
    check($sformatf("v%0d count", idx), 32'(count_a), 32'(v.exp_count));
    if (v.last) begin
      check($sformatf("v%0d done", idx), 32'(done_a), 32'd1);
      check($sformatf("v%0d busy", idx), 32'(busy_a), 32'd0);
      check($sformatf("v%0d err", idx), 32'(err_a), 32'd0);
      tick();
      check($sformatf("v%0d done one cycle", idx), 32'(done_a), 32'd0);
    end else begin
      check($sformatf("v%0d back to load", idx), 32'(in_ready_a), 32'd1);
      check($sformatf("v%0d no done", idx), 32'(done_a), 32'd0);
    end
  endtask

  initial begin
    int          n_wr, n_acc, n_done;
    logic [31:0] wr_addr [8];

    // ADD R1,R2,#5 / LDR R3,[R0,#8] / SUBS R1,R1,#1 / B -3
    vecs[0] = '{1'b1, 4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 24'h000005, 1'b1, 0, 32'h0, 32'hE2821005, 7'd1};
    vecs[1] = '{1'b1, 4'hE, 2'b01, 6'b011001, 4'd0, 4'd3, 24'hABC008, 1'b0, 0, 32'h0, 32'hE5903008, 7'd1};
    vecs[2] = '{1'b0, 4'hE, 2'b00, 6'b100101, 4'd1, 4'd1, 24'h000001, 1'b0, 3, 32'h4, 32'hE2511001, 7'd2};
    vecs[3] = '{1'b0, 4'hE, 2'b10, 6'b100101, 4'h7, 4'h9, 24'hFFFFFD, 1'b1, 0, 32'h8, 32'hEAFFFFFD, 7'd3};

    // Reset with inputs toggling
    rst_n = 1'b0; start = 1'b1; start_b = 1'b1; in_valid = 1'b1; in_last = 1'b1;
    imem_ready = 1'b1; in_cond = 4'hF; in_op = 2'b01; in_funct = 6'h3F;
    in_rn = 4'hF; in_rd = 4'hF; in_operand = 24'hFFFFFF;
    tick();
    start = 1'b0; in_valid = 1'b0; in_op = 2'b10; in_operand = 24'h0;
    tick();
    check("rst in_ready", 32'(in_ready_a), 32'd0);
    check("rst we", 32'(imem_we_a), 32'd0);
    check("rst addr", imem_addr_a, 32'h0);
    check("rst wdata", imem_wdata_a, 32'h0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    check("rst err", 32'(err_a), 32'd0);
    check("rst count", 32'(count_a), 32'd0);
    start_b = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle ignores inputs", 32'(busy_a), 32'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Illegal op mid-session
    run_vec(vecs[1], 10);
    drive(vecs[0]);
    in_op = OP_ILL; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ill done", 32'(done_a), 32'd1);
    check("ill err", 32'(err_a), 32'd1);
    check("ill no write", 32'(imem_we_a), 32'd0);
    check("ill count", 32'(count_a), 32'd1);
    check("ill busy", 32'(busy_a), 32'd0);
    tick();
    check("ill done pulse", 32'(done_a), 32'd0);
    check("ill err sticky", 32'(err_a), 32'd1);
    check("ill addr held", imem_addr_a, 32'h4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart err", 32'(err_a), 32'd0);
    check("restart addr", imem_addr_a, 32'h0);
    check("restart count", 32'(count_a), 32'd0);
    check("restart in_ready", 32'(in_ready_a), 32'd1);

    // Reset while a write is pending
    imem_ready = 1'b0;
    drive(vecs[0]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pre-rst we", 32'(imem_we_a), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid rst we", 32'(imem_we_a), 32'd0);
    check("mid rst busy", 32'(busy_a), 32'd0);
    check("mid rst wdata", imem_wdata_a, 32'h0);
    rst_n = 1'b1; imem_ready = 1'b1;
    tick();
    run_vec(vecs[0], 20);

    // Overflow on the DEPTH=4 instance
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    drive(vecs[2]);
    in_last = 1'b0; in_valid = 1'b1;
    n_wr = 0; n_acc = 0; n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (imem_we_b && imem_ready && n_wr < 8) begin
        wr_addr[n_wr] = imem_addr_b;
        n_wr++;
      end
      if (in_valid && in_ready_b) n_acc++;
      if (done_b) n_done++;
      tick();
    end
    in_valid = 1'b0;
    check("ovf writes", 32'(n_wr), 32'd4);
    check("ovf accepted", 32'(n_acc), 32'd4);
    check("ovf done pulses", 32'(n_done), 32'd1);
    check("ovf err", 32'(err_b), 32'd1);
    check("ovf count", 32'(count_b), 32'd4);
    check("ovf in_ready", 32'(in_ready_b), 32'd0);
    for (int k = 0; k < 4 && k < n_wr; k++)
      check($sformatf("ovf addr%0d", k), wr_addr[k], 32'(4 * k));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
